clock_time_keeper: RTL



---
 rtl/clock_pkg.sv | 15 +
 rtl/bcd2_mod_counter.sv | 45 ++++
 rtl/clock_time_keeper.sv | 112 +++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared constants and BCD validation helper for the time-of-day keeper.
package clock_pkg;

  localparam int         C_BCD_W    = 4;
  localparam logic [9:0] C_MS_MAX   = 10'd999;
  localparam logic [7:0] C_SEC_MAX  = 8'h59;
  localparam logic [7:0] C_MIN_MAX  = 8'h59;
  localparam logic [7:0] C_HOUR_MAX = 8'h23;

  // Valid BCD orders the same as binary, so the range check is a plain compare.
  function automatic logic bcd2_valid(input logic [7:0] value, input logic [7:0] max);
    return (value[C_BCD_W-1:0] <= 4'd9) && (value[2*C_BCD_W-1:C_BCD_W] <= 4'd9) && (value <= max);
  endfunction

endpackage

// File: rtl/bcd2_mod_counter.sv
// Two-digit packed-BCD modulo counter with synchronous load; wrap flags the max->00 step.
module bcd2_mod_counter
  import clock_pkg::*;
#(
  parameter logic [7:0] P_MAX   = C_SEC_MAX,
  parameter logic [7:0] P_RESET = 8'h00
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_inc,
  input  logic       i_load,
  input  logic [7:0] i_load_value,
  output logic [7:0] o_value,
  output logic       o_wrap
);

  logic [C_BCD_W-1:0] ones;
  logic [C_BCD_W-1:0] tens;
  logic [7:0]         next_inc;

  assign ones = o_value[C_BCD_W-1:0];
  assign tens = o_value[2*C_BCD_W-1:C_BCD_W];

  always_comb begin
    next_inc = {tens, ones + 4'd1};
    if (o_value == P_MAX) begin
      next_inc = 8'h00;
    end else if (ones == 4'd9) begin
      next_inc = {tens + 4'd1, 4'd0};
    end
  end

  assign o_wrap = i_inc & (o_value == P_MAX);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_value <= P_RESET;
    end else if (i_load) begin
      o_value <= i_load_value;
    end else if (i_inc) begin
      o_value <= next_inc;
    end
  end

endmodule

// File: rtl/clock_time_keeper.sv
// Time-of-day keeper: ms counter plus BCD seconds/minutes/hours with load, adjust and rollover ticks.
module clock_time_keeper
  import clock_pkg::*;
#(
  parameter int         P_MS_PER_SEC = 1000,
  parameter logic [7:0] P_RESET_HH   = 8'h00,
  parameter logic [7:0] P_RESET_MM   = 8'h00
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_ms_pulse,
  input  logic       i_run,
  input  logic       i_load,
  input  logic [7:0] i_load_hh,
  input  logic [7:0] i_load_mm,
  input  logic [7:0] i_load_ss,
  input  logic       i_inc_min,
  input  logic       i_inc_hour,
  output logic [9:0] o_ms,
  output logic [7:0] o_ss,
  output logic [7:0] o_mm,
  output logic [7:0] o_hh,
  output logic       o_sec_tick,
  output logic       o_min_tick,
  output logic       o_day_tick,
  output logic       o_load_err
);

  localparam logic [9:0] MS_MAX = 10'(P_MS_PER_SEC - 1);

  logic load_valid;
  logic load_ok;
  logic load_bad;
  logic advance;
  logic ms_wrap;
  logic sec_wrap;
  logic min_wrap;
  logic hour_wrap;
  logic min_carry;
  logic min_inc;
  logic hour_inc;

  assign load_valid = bcd2_valid(i_load_hh, C_HOUR_MAX)
                    & bcd2_valid(i_load_mm, C_MIN_MAX)
                    & bcd2_valid(i_load_ss, C_SEC_MAX);
  assign load_ok    = i_load & load_valid;
  assign load_bad   = i_load & ~load_valid;

  // A valid load swallows any coincident pulse or adjust; a rejected one does not.
  assign advance    = i_ms_pulse & i_run & ~load_ok;
  assign ms_wrap    = advance & (o_ms == MS_MAX);

  // An adjust on a field replaces that field's carry, so the carry stops there.
  assign min_inc    = ~load_ok & (i_inc_min | sec_wrap);
  assign min_carry  = min_wrap & ~i_inc_min;
  assign hour_inc   = ~load_ok & (i_inc_hour | min_carry);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_ms <= '0;
    end else if (load_ok) begin
      o_ms <= '0;
    end else if (advance) begin
      o_ms <= ms_wrap ? 10'd0 : o_ms + 10'd1;
    end
  end

  bcd2_mod_counter #(.P_MAX(C_SEC_MAX), .P_RESET(8'h00)) u_sec (
    .i_clk        (i_clk),
    .i_rstn       (i_rstn),
    .i_inc        (ms_wrap),
    .i_load       (load_ok),
    .i_load_value (i_load_ss),
    .o_value      (o_ss),
    .o_wrap       (sec_wrap)
  );

  bcd2_mod_counter #(.P_MAX(C_MIN_MAX), .P_RESET(P_RESET_MM)) u_min (
    .i_clk        (i_clk),
    .i_rstn       (i_rstn),
    .i_inc        (min_inc),
    .i_load       (load_ok),
    .i_load_value (i_load_mm),
    .o_value      (o_mm),
    .o_wrap       (min_wrap)
  );

  bcd2_mod_counter #(.P_MAX(C_HOUR_MAX), .P_RESET(P_RESET_HH)) u_hour (
    .i_clk        (i_clk),
    .i_rstn       (i_rstn),
    .i_inc        (hour_inc),
    .i_load       (load_ok),
    .i_load_value (i_load_hh),
    .o_value      (o_hh),
    .o_wrap       (hour_wrap)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_sec_tick <= 1'b0;
      o_min_tick <= 1'b0;
      o_day_tick <= 1'b0;
      o_load_err <= 1'b0;
    end else begin
      o_sec_tick <= ms_wrap;
      o_min_tick <= sec_wrap & ~i_inc_min;
      o_day_tick <= hour_wrap & ~i_inc_hour;
      o_load_err <= load_bad;
    end
  end

endmodule
